cache_ram_bridge: RTL and testbench
===================================

Name: cache_ram_bridge

Overview:
- Sits directly downstream of the cache manage unit, between its block-wide RAM request port and a 32-bit word-wide main-memory port.
- Converts each block request (load or writeback of BLOCK_SIZE words) into a sequence of single-word memory beats.
- Gathers read beats into a full block and returns it with a one-cycle ready pulse.

Parameters:
OFFSET_WIDTH, 3, block offset width; BLOCK_SIZE = 1 << OFFSET_WIDTH words per block
ADDR_WIDTH, 30, word address width
DATA_WIDTH, 32, word width in bits
BLOCK_WIDTH, DATA_WIDTH*BLOCK_SIZE, block width in bits (derived)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
ram_en  input  1  block request from cache; level, held while the cache is stalled
ram_write  input  1  1 = writeback block, 0 = load block
ram_addr  input  ADDR_WIDTH  block base word address; low OFFSET_WIDTH bits are zero
wb_block  input  BLOCK_WIDTH  block to write back; word i = bits [DATA_WIDTH*i +: DATA_WIDTH]
ram_ready  output  1  one-cycle pulse: request complete
block_out  output  BLOCK_WIDTH  last loaded block
busy  output  1  high in BURST and DONE
mem_req  output  1  word beat request
mem_we  output  1  beat is a write
mem_addr  output  ADDR_WIDTH  beat word address
mem_wdata  output  DATA_WIDTH  beat write data
mem_ack  input  1  beat accepted/completed in this cycle
mem_rdata  input  DATA_WIDTH  read data, valid when mem_ack=1 and mem_we=0

Behaviour:
- Reset, asynchronous on rst_n low:
  - state IDLE, beat counter 0.
  - ram_ready, mem_req, mem_we, busy = 0.
  - mem_addr, mem_wdata, block_out = 0.
  - Reset mid-burst aborts immediately; no ready pulse is produced.
- FSM states:
  - IDLE:
    - If ram_en=1 at the clock edge, latch ram_write, ram_addr, and wb_block (writes only), clear the counter, and go to BURST.
    - mem_req=0.
  - BURST:
    - mem_req=1, mem_we = latched write, mem_addr = latched base + counter, mem_wdata = latched word[counter].
    - Outputs stay stable until mem_ack=1.
    - On a cycle with mem_ack=1 and a read, capture mem_rdata into the block_out word[counter] slot via a shadow buffer. block_out itself updates only when the whole block completes.
    - On mem_ack with counter < BLOCK_SIZE-1, counter increments.
    - On mem_ack with counter = BLOCK_SIZE-1, go to DONE; on a read, copy the shadow block to block_out on the same edge.
  - DONE:
    - ram_ready=1 for exactly this cycle; mem_req=0.
    - Next state is IDLE unconditionally. The cache updates its status on this edge, so ram_en is re-sampled one cycle later with the new command. A dirty miss (writeback then load) is two back-to-back requests.
- Latency: zero-wait memory (mem_ack tied 1) gives request-sampled edge → ram_ready = BLOCK_SIZE+1 cycles (9 by default). Each wait cycle adds 1.
- Command inputs are ignored in BURST and DONE. ram_en dropping mid-burst does not abort; the burst completes and still pulses ram_ready.
- mem_ack while not in BURST is ignored.
- block_out holds its value across writebacks and IDLE; it changes only at read completion.
- Counter is OFFSET_WIDTH bits. The address adder is ADDR_WIDTH bits; the base is block-aligned, so no carry into the tag/index bits occurs.

Test Plan:
- Reset: rst_n=0 asynchronously mid-BURST (beat 3) → mem_req=0, busy=0 immediately, with no clock edge needed. After release and ram_en=0 → state stays IDLE, with no mem_req.
- Zero-wait load: ram_en=1, write=0, addr=0x00000040, mem_rdata = 0x1000+addr.
  - Beats go to addresses 0x40..0x47.
  - ram_ready pulses on cycle 9.
  - block_out word i = 0x1040+i.
- Writeback with waits: wb_block word i = 0xA0+i, addr=0x00000080, mem_ack high every 3rd cycle.
  - 8 beats with mem_we=1 and data 0xA0..0xA7, each held stable until ack.
  - ram_ready pulses once.
  - block_out is unchanged.
- Dirty miss sequence: writeback to 0x80, then ram_en held high with write=0 and addr=0x100 after ready.
  - Second burst starts the cycle after IDLE.
  - Exactly 2 ready pulses and 16 beats in total.
- ram_en deasserted at beat 2 of a load → all 8 beats complete and ram_ready pulses. A spurious mem_ack in IDLE → no state change.

Source files
------------

// File: rtl/cache_ram_bridge.sv
// cache_ram_bridge: splits block-wide cache RAM requests into single-word
// memory beats and gathers read beats back into a full block.
module cache_ram_bridge #(
    parameter int OFFSET_WIDTH = 3,
    parameter int ADDR_WIDTH   = 30,
    parameter int DATA_WIDTH   = 32,
    parameter int BLOCK_WIDTH  = DATA_WIDTH * (1 << OFFSET_WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ram_en,
    input  logic                   ram_write,
    input  logic [ADDR_WIDTH-1:0]  ram_addr,
    input  logic [BLOCK_WIDTH-1:0] wb_block,
    output logic                   ram_ready,
    output logic [BLOCK_WIDTH-1:0] block_out,
    output logic                   busy,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0]  mem_wdata,
    input  logic                   mem_ack,
    input  logic [DATA_WIDTH-1:0]  mem_rdata
);

    localparam int BLOCK_SIZE = 1 << OFFSET_WIDTH;
    localparam logic [OFFSET_WIDTH-1:0] LAST_BEAT = OFFSET_WIDTH'(BLOCK_SIZE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [OFFSET_WIDTH-1:0] cnt_q, cnt_d;
    logic                    write_q, write_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [BLOCK_WIDTH-1:0]  wb_q, wb_d;
    logic [BLOCK_WIDTH-1:0]  shadow_q, shadow_d;
    logic [BLOCK_WIDTH-1:0]  block_out_q, block_out_d;

    logic beat_done;
    logic last_beat;

    assign beat_done = (state_q == BURST) && mem_ack;
    assign last_beat = (cnt_q == LAST_BEAT);
    assign block_out = block_out_q;

    // State register; reset mid-burst aborts straight back to IDLE.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE waits for a request, BURST runs BLOCK_SIZE acked beats, DONE lasts one cycle.
    // NOTE: a default assignment first keeps this combinational block latch-free.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ram_en) state_d = BURST;
            BURST:   if (mem_ack && last_beat) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: beat fields are driven only in BURST and held until acked because the flops only move on ack.
    always_comb begin
        ram_ready = (state_q == DONE);
        busy      = (state_q != IDLE);
        mem_req   = (state_q == BURST);
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state_q == BURST) begin
            mem_we    = write_q;
            mem_addr  = base_q + ADDR_WIDTH'(cnt_q);
            mem_wdata = wb_q[DATA_WIDTH*cnt_q +: DATA_WIDTH];
        end
    end

    // Datapath registers: latched command, beat counter, shadow gather buffer and returned block.
    // NOTE: the wide data registers are reset too, since block_out must read zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            write_q     <= 1'b0;
            base_q      <= '0;
            wb_q        <= '0;
            shadow_q    <= '0;
            block_out_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            base_q      <= base_d;
            wb_q        <= wb_d;
            shadow_q    <= shadow_d;
            block_out_q <= block_out_d;
        end
    end

    // Datapath next values: latch on acceptance, advance per ack, publish the gathered block on the final read beat.
    // NOTE: blocking (=) here lets block_out_d see this cycle's shadow_d, so the last read word lands on the same edge.
    always_comb begin
        cnt_d       = cnt_q;
        write_d     = write_q;
        base_d      = base_q;
        wb_d        = wb_q;
        shadow_d    = shadow_q;
        block_out_d = block_out_q;

        if (state_q == IDLE && ram_en) begin
            write_d = ram_write;
            base_d  = ram_addr;
            cnt_d   = '0;
            if (ram_write) wb_d = wb_block;
        end

        if (beat_done) begin
            if (!write_q) shadow_d[DATA_WIDTH*cnt_q +: DATA_WIDTH] = mem_rdata;
            if (!last_beat) begin
                cnt_d = cnt_q + 1'b1;
            end else if (!write_q) begin
                block_out_d = shadow_d;
            end
        end
    end

endmodule

// File: tb/tb_cache_ram_bridge.sv
// Scoreboard bench for cache_ram_bridge: stimulus pushes expected beats and
// completions into queues; a negedge monitor pops and compares them.
module tb_cache_ram_bridge;

    localparam int AW = 30;
    localparam int DW = 32;
    localparam int BW = 256;
    localparam int NB = 8;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ram_en = 1'b0;
    logic          ram_write = 1'b0;
    logic [AW-1:0] ram_addr = '0;
    logic [BW-1:0] wb_block = '0;
    logic          ram_ready;
    logic [BW-1:0] block_out;
    logic          busy;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata;

    cache_ram_bridge dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ram_en    (ram_en),
        .ram_write (ram_write),
        .ram_addr  (ram_addr),
        .wb_block  (wb_block),
        .ram_ready (ram_ready),
        .block_out (block_out),
        .busy      (busy),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int ack_mode = 0;   // 0: ack every cycle, 1: ack every 3rd cycle
    int beat_cnt = 0;
    int ready_cnt = 0;

    beat_t         beat_q[$];
    logic [BW-1:0] ready_q[$];
    logic [BW-1:0] exp_block = '0;

    task automatic check(input string name, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: read data is 0x1000 + word address; ack pattern per mode.
    always_comb mem_rdata = 32'h1000 + {2'b00, mem_addr};

    always @(posedge clk) begin
        #1;
        mem_ack = (ack_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
    end

    // Monitor: compare presented beats against the queue head, pop on ack; pop completions on ram_ready.
    always @(negedge clk) begin
        if (mem_req) begin
            if (beat_q.size() == 0) begin
                check("unexpected_beat", 1'b1, 1'b0);
            end else begin
                check("beat_we", mem_we, beat_q[0].we);
                check("beat_addr", mem_addr, beat_q[0].addr);
                if (beat_q[0].we) check("beat_wdata", mem_wdata, beat_q[0].data);
                if (mem_ack) begin
                    void'(beat_q.pop_front());
                    beat_cnt++;
                end
            end
        end
        if (ram_ready) begin
            ready_cnt++;
            if (ready_q.size() == 0) check("unexpected_ready", 1'b1, 1'b0);
            else check("block_out", block_out, ready_q.pop_front());
        end
    end

    // Issue a request right after a negedge; queue its beats and completion block.
    task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [BW-1:0] wb);
        for (int i = 0; i < NB; i++) begin
            beat_q.push_back('{we: wr, addr: addr + AW'(i), data: wb[DW*i +: DW]});
            if (!wr) exp_block[DW*i +: DW] = 32'h1000 + {2'b00, addr} + 32'(i);
        end
        ready_q.push_back(exp_block);
        ram_en    = 1'b1;
        ram_write = wr;
        ram_addr  = addr;
        wb_block  = wb;
    endtask

    // Wait (bounded) for ram_ready at a negedge; returns the cycle it was seen.
    task automatic wait_ready(input int budget, output int seen);
        seen = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (ram_ready) begin
                seen = cyc;
                break;
            end
        end
        if (seen < 0) check("ready_timeout", 1'b1, 1'b0);
    endtask

    function automatic logic [BW-1:0] make_wb(input logic [DW-1:0] first);
        logic [BW-1:0] b;
        for (int i = 0; i < NB; i++) b[DW*i +: DW] = first + 32'(i);
        return b;
    endfunction

    initial begin
        int s, r, r1, m, b0, p0;
        #2 forever #200000 begin
            $display("FAIL watchdog: simulation did not finish");
            $fatal(1, "watchdog");
        end
    end

    initial begin
        int s, r, r1, m, b0, p0;

        // Reset values
        #12;
        check("rst_ready", ram_ready, 1'b0);
        check("rst_req", mem_req, 1'b0);
        check("rst_we", mem_we, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_addr", mem_addr, '0);
        check("rst_wdata", mem_wdata, '0);
        check("rst_block", block_out, '0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Zero-wait load at 0x40: beats 0x40..0x47, ready on cycle 9, block word i = 0x1040+i
        ack_mode = 0;
        issue(1'b0, 30'h40, '0);
        @(posedge clk); #1 s = cyc;
        wait_ready(40, r);
        check("load_latency", 32'(r + 1 - s), 32'd9);
        ram_en = 1'b0;

        // Writeback with waits at 0x80, data 0xA0+i; block_out unchanged
        repeat (2) @(negedge clk);
        ack_mode = 1;
        issue(1'b1, 30'h80, make_wb(32'hA0));
        wait_ready(100, r);
        ram_en = 1'b0;
        check("wb_block_kept", block_out, exp_block);
        @(negedge clk);
        check("ready_one_cycle", ram_ready, 1'b0);

        // Dirty miss: writeback 0x80 then load 0x100 with ram_en held high
        @(negedge clk);
        ack_mode = 0;
        b0 = beat_cnt;
        p0 = ready_cnt;
        issue(1'b1, 30'h80, make_wb(32'hB0));
        wait_ready(40, r1);
        issue(1'b0, 30'h100, '0);
        m = -1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (mem_req) begin
                m = cyc;
                break;
            end
        end
        check("dirty_restart_gap", 32'(m - r1), 32'd2);
        wait_ready(40, r);
        ram_en = 1'b0;
        @(negedge clk);
        check("dirty_beats", 32'(beat_cnt - b0), 32'd16);
        check("dirty_readies", 32'(ready_cnt - p0), 32'd2);

        // Load at 0x180 with ram_en dropped at beat 2: still completes
        @(negedge clk);
        issue(1'b0, 30'h180, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        ram_en = 1'b0;
        wait_ready(40, r);

        // Spurious ack in IDLE: no state change
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("idle_ack_busy", busy, 1'b0);
            check("idle_ack_req", mem_req, 1'b0);
        end

        // Asynchronous reset mid-burst at beat 3
        issue(1'b0, 30'h200, '0);
        @(posedge clk); #1;
        repeat (3) @(posedge clk);
        #2;
        check("mid_burst_addr", mem_addr, 30'h203);
        ram_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("async_rst_req", mem_req, 1'b0);
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_block", block_out, '0);
        beat_q.delete();
        ready_q.delete();
        exp_block = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("post_rst_busy", busy, 1'b0);
            check("post_rst_req", mem_req, 1'b0);
        end

        check("beats_drained", 32'(beat_q.size()), 32'd0);
        check("readies_drained", 32'(ready_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
